// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// core_seq_ctrl : per-tile instruction sequencer for the PE array core
//   weight fetch/load, propagation gap, activation fetch/execute, psum drain
// Revision: 1.0
// ============================================================================
module core_seq_ctrl #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int ADDR_BW  = 11,
  parameter int PROP_GAP = ROW + COL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW-1:0] w_base,
  input  logic [ADDR_BW-1:0] x_base,
  input  logic [ADDR_BW-1:0] p_base,
  input  logic [ADDR_BW-1:0] num_act,
  input  logic               relu_en,
  input  logic               acc_en,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               busy,
  output logic               done
);

  localparam logic [34:0]        c_IDLE_INST = 35'h1_800C_0000;
  localparam logic [ADDR_BW-1:0] c_COL       = ADDR_BW'(COL);
  localparam logic [ADDR_BW-1:0] c_COL_M1    = ADDR_BW'(COL - 1);
  localparam logic [ADDR_BW-1:0] c_GAP_M1    = ADDR_BW'(PROP_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFETCH = 3'd1,
    S_WLOAD  = 3'd2,
    S_WPROP  = 3'd3,
    S_XFETCH = 3'd4,
    S_EXEC   = 3'd5,
    S_DRAIN  = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  state_t             r_state;
  logic [ADDR_BW-1:0] r_cnt;
  logic [ADDR_BW-1:0] r_w_base;
  logic [ADDR_BW-1:0] r_x_base;
  logic [ADDR_BW-1:0] r_p_base;
  logic [ADDR_BW-1:0] r_num;
  logic               r_relu;
  logic               r_acc;

  logic [ADDR_BW-1:0] w_num_eff;
  logic [ADDR_BW-1:0] w_num_m1;

  assign w_num_eff = (num_act == '0) ? ADDR_BW'(1) : num_act;
  assign w_num_m1  = r_num - ADDR_BW'(1);

  // SRAM read issued on idx < limit; l0_wr lags the read address by one cycle.
  function automatic logic [34:0] fetch_word(input logic [ADDR_BW-1:0] base,
                                             input logic [ADDR_BW-1:0] idx,
                                             input logic               rd_en,
                                             input logic               wr_en);
    logic [34:0] w;
    w = c_IDLE_INST;
    if (rd_en) begin
      w[19]   = 1'b0;
      w[17:7] = base + idx;
    end
    w[2] = wr_en;
    return w;
  endfunction

  function automatic logic [34:0] drain_word(input logic [ADDR_BW-1:0] addr,
                                             input logic               relu,
                                             input logic               acc);
    logic [34:0] w;
    w        = c_IDLE_INST;
    w[34]    = relu;
    w[33]    = acc;
    w[32]    = 1'b0;
    w[31]    = 1'b0;
    w[30:20] = addr;
    w[6]     = 1'b1;
    return w;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_w_base <= '0;
      r_x_base <= '0;
      r_p_base <= '0;
      r_num    <= '0;
      r_relu   <= 1'b0;
      r_acc    <= 1'b0;
      inst     <= c_IDLE_INST;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          inst <= c_IDLE_INST;
          if (start) begin
            r_w_base <= w_base;
            r_x_base <= x_base;
            r_p_base <= p_base;
            r_num    <= w_num_eff;
            r_relu   <= relu_en;
            r_acc    <= acc_en;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_WFETCH;
          end
        end

        S_WFETCH: begin
          inst <= fetch_word(r_w_base, r_cnt, r_cnt != c_COL, r_cnt != '0);
          if (r_cnt == c_COL) begin
            r_cnt   <= '0;
            r_state <= S_WLOAD;
          end else begin
            r_cnt <= r_cnt + ADDR_BW'(1);
          end
        end

        S_WLOAD: begin
          inst <= c_IDLE_INST | 35'h0_0000_0009;
          if (r_cnt == c_COL_M1) begin
            r_cnt   <= '0;
            r_state <= S_WPROP;
          end else begin
            r_cnt <= r_cnt + ADDR_BW'(1);
          end
        end

        S_WPROP: begin
          inst <= c_IDLE_INST;
          if (r_cnt == c_GAP_M1) begin
            r_cnt   <= '0;
            r_state <= S_XFETCH;
          end else begin
            r_cnt <= r_cnt + ADDR_BW'(1);
          end
        end

        S_XFETCH: begin
          inst <= fetch_word(r_x_base, r_cnt, r_cnt != r_num, r_cnt != '0);
          if (r_cnt == r_num) begin
            r_cnt   <= '0;
            r_state <= S_EXEC;
          end else begin
            r_cnt <= r_cnt + ADDR_BW'(1);
          end
        end

        S_EXEC: begin
          inst <= c_IDLE_INST | 35'h0_0000_000A;
          if (r_cnt == w_num_m1) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + ADDR_BW'(1);
          end
        end

        // The result index only advances on cycles where the FIFO offers data.
        S_DRAIN: begin
          if (ofifo_valid) begin
            inst <= drain_word(r_p_base + r_cnt, r_relu, r_acc);
            if (r_cnt == w_num_m1) begin
              r_cnt   <= '0;
              r_state <= S_FIN;
            end else begin
              r_cnt <= r_cnt + ADDR_BW'(1);
            end
          end else begin
            inst <= c_IDLE_INST;
          end
        end

        S_FIN: begin
          inst    <= c_IDLE_INST;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          inst    <= c_IDLE_INST;
          busy    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// Bench for core_seq_ctrl: a sequence-level reference model checked every cycle,
// plus directed tiles with literal expectations and randomized tiles.
module tb_core_seq_ctrl;

  localparam int COL      = 8;
  localparam int PROP_GAP = 16;
  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        acc_en = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, p_base = '0, num_act = '0;
  logic [34:0] inst;
  logic        busy, done;

  core_seq_ctrl #(.ROW(8), .COL(8), .ADDR_BW(11), .PROP_GAP(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .num_act(num_act),
    .relu_en(relu_en), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int vmode = 0;
  bit chk_on = 1'b0;

  // ---------------- reference model ----------------
  logic [34:0] exp_inst;
  logic        exp_busy, exp_done;
  logic [34:0] pre_q[$];
  bit          m_busy;
  int          m_d, m_n;
  logic [10:0] m_p;
  logic        m_relu, m_acc;

  function automatic logic [34:0] mk(bit pcen, bit pwen, logic [10:0] pa,
                                     bit xcen, bit xwen, logic [10:0] xa,
                                     bit ofr, bit l0rd, bit l0wr, bit ex, bit ld,
                                     bit relu, bit acc);
    return {relu, acc, pcen, pwen, pa, xcen, xwen, xa, ofr, 2'b00, l0rd, l0wr, ex, ld};
  endfunction

  // Fetch phase: len+1 words; read base+i on word i, l0_wr on word i+1.
  task automatic add_fetch(input logic [10:0] base, input int len);
    int s;
    logic [34:0] t;
    s = pre_q.size();
    for (int i = 0; i <= len; i++) pre_q.push_back(IDLE_W);
    for (int i = 0; i < len; i++) begin
      t = pre_q[s+i];
      t[19] = 1'b0;
      t[17:7] = base + 11'(i);
      pre_q[s+i] = t;
      t = pre_q[s+i+1];
      t[2] = 1'b1;
      pre_q[s+i+1] = t;
    end
  endtask

  task automatic build_tile(input logic [10:0] wb, input logic [10:0] xb, input int n);
    pre_q.delete();
    add_fetch(wb, COL);
    for (int i = 0; i < COL; i++) pre_q.push_back(mk(1,1,0,1,1,0,0,1,0,0,1,0,0));
    for (int i = 0; i < PROP_GAP; i++) pre_q.push_back(IDLE_W);
    add_fetch(xb, n);
    for (int i = 0; i < n; i++) pre_q.push_back(mk(1,1,0,1,1,0,0,1,0,1,0,0,0));
  endtask

  initial begin
    exp_inst = IDLE_W;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    m_busy   = 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_inst = IDLE_W;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      m_busy   = 1'b0;
      pre_q.delete();
    end else begin
      exp_done = 1'b0;
      if (!m_busy) begin
        exp_inst = IDLE_W;
        if (start) begin
          m_n    = (num_act == 0) ? 1 : int'(num_act);
          m_p    = p_base;
          m_relu = relu_en;
          m_acc  = acc_en;
          m_d    = 0;
          build_tile(w_base, x_base, m_n);
          m_busy   = 1'b1;
          exp_busy = 1'b1;
        end
      end else if (pre_q.size() > 0) begin
        exp_inst = pre_q.pop_front();
      end else if (m_d < m_n) begin
        if (ofifo_valid) begin
          exp_inst = mk(0,0,m_p + 11'(m_d),1,1,0,1,0,0,0,0,m_relu,m_acc);
          m_d++;
        end else begin
          exp_inst = IDLE_W;
        end
      end else begin
        exp_inst = IDLE_W;
        exp_done = 1'b1;
        exp_busy = 1'b0;
        m_busy   = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      n_vec++;
      if (inst !== exp_inst || busy !== exp_busy || done !== exp_done ||
          (!inst[32] && !inst[19])) begin
        n_err++;
        $display("FAIL cycle t=%0t inst=%h exp=%h busy=%b exp=%b done=%b exp=%b",
                 $time, inst, exp_inst, busy, exp_busy, done, exp_done);
      end
    end
  end

  // ofifo_valid source: 0 tied high, 1 random, 2 pattern 1,0,0,...
  initial begin
    int pc;
    pc = 0;
    forever begin
      @(negedge clk);
      case (vmode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = 1'($urandom_range(0, 1));
        default: ofifo_valid = (pc % 3 == 0);
      endcase
      pc++;
    end
  end

  // ---------------- directed helpers ----------------
  logic [34:0] tr[$];
  logic [10:0] pq[$];
  logic [10:0] xq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                        input logic [10:0] n, input logic re, input logic ae);
    @(negedge clk);
    w_base = wb; x_base = xb; p_base = pb; num_act = n;
    relu_en = re; acc_en = ae;
    start = 1'b1;
  endtask

  task automatic wait_done(input int n_eff, input bit cyc_chk, input int pulse_at);
    int cyc;
    cyc = 0;
    tr.delete(); pq.delete(); xq.delete();
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == pulse_at) begin
        start = 1'b1;
        w_base = 11'd1500; x_base = 11'd1600; p_base = 11'd1700; num_act = 11'd3;
      end else begin
        start = 1'b0;
      end
      tr.push_back(inst);
      if (!inst[32]) pq.push_back(inst[30:20]);
      if (!inst[19]) xq.push_back(inst[17:7]);
    end while (!done && cyc < 5000);
    chk("done_seen", 64'(done), 64'd1);
    if (cyc_chk) chk("latency", 64'(cyc - 1), 64'(2*COL + 2*n_eff + PROP_GAP + 2 + n_eff + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [34:0] t;
    int cnt;
    int n;
    logic [10:0] xe[4];
    logic [10:0] pe[4];

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst", 64'(inst), 64'(35'h1_800C_0000));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    chk_on = 1'b1;

    // reset in the middle of EXEC
    vmode = 0;
    launch(11'd0, 11'd50, 11'd60, 11'd10, 1'b0, 1'b0);
    repeat (48) begin @(negedge clk); start = 1'b0; end
    chk("pre_rst_exec", 64'(inst[1]), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_inst", 64'(inst), 64'(35'h1_800C_0000));
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // weight phase literals
    launch(11'd0, 11'd20, 11'd0, 11'd3, 1'b0, 1'b0);
    wait_done(3, 1'b1, 0);
    chk("wf0", 64'(tr[1]), 64'(35'h1_8004_0000));
    chk("wf1", 64'(tr[2]), 64'(35'h1_8004_0084));
    chk("wf_tail", 64'(tr[9]), 64'(35'h1_800C_0004));
    chk("wload", 64'(tr[10]), 64'(35'h1_800C_0009));
    chk("wprop", 64'(tr[18]), 64'(35'h1_800C_0000));
    chk("xmem_reads", 64'(xq.size()), 64'd11);

    // full tile
    launch(11'd300, 11'd100, 11'd5, 11'd36, 1'b0, 1'b0);
    wait_done(36, 1'b1, 0);
    chk("tile_cycles", 64'(tr.size() - 1), 64'd143);
    chk("pmem_count", 64'(pq.size()), 64'd36);
    chk("pmem_first", 64'(pq[0]), 64'd5);
    chk("pmem_last", 64'(pq[35]), 64'd40);
    foreach (tr[i]) begin
      t = tr[i];
      if (!t[32]) begin
        chk("drain_word", 64'(t), 64'(35'h0_005C_0040));
        break;
      end
    end

    // drain stall pattern
    vmode = 2;
    launch(11'd10, 11'd200, 11'd1000, 11'd12, 1'b1, 1'b0);
    wait_done(12, 1'b0, 0);
    vmode = 0;
    chk("stall_count", 64'(pq.size()), 64'd12);
    foreach (pq[i]) chk("stall_contig", 64'(pq[i]), 64'(1000 + i));

    // address wrap and flags
    launch(11'd0, 11'd2046, 11'd2047, 11'd4, 1'b1, 1'b1);
    wait_done(4, 1'b1, 0);
    xe = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    pe = '{11'd2047, 11'd0, 11'd1, 11'd2};
    chk("wrap_xcount", 64'(xq.size()), 64'd12);
    chk("wrap_pcount", 64'(pq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_xaddr", 64'(xq[8+i]), 64'(xe[i]));
      chk("wrap_paddr", 64'(pq[i]), 64'(pe[i]));
    end
    cnt = 0;
    foreach (tr[i]) begin
      t = tr[i];
      if (t[34:33] == 2'b11) cnt++;
    end
    chk("flag_cycles", 64'(cnt), 64'd4);

    // start while busy (pulse lands in XFETCH)
    launch(11'd40, 11'd60, 11'd80, 11'd20, 1'b0, 1'b1);
    wait_done(20, 1'b1, 36);
    chk("busy_start_p0", 64'(pq[0]), 64'd80);
    chk("busy_start_pn", 64'(pq.size()), 64'd20);

    // num_act = 0 behaves as 1
    launch(11'd5, 11'd6, 11'd7, 11'd0, 1'b0, 1'b0);
    wait_done(1, 1'b1, 0);
    chk("zero_act_writes", 64'(pq.size()), 64'd1);

    // randomized tiles
    for (int k = 0; k < 6; k++) begin
      vmode = $urandom_range(0, 2);
      n = $urandom_range(1, 40);
      launch(11'($urandom), 11'($urandom), 11'($urandom), 11'(n),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(n, vmode == 0, 0);
      chk("rand_writes", 64'(pq.size()), 64'(n));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Instruction sequencer directly upstream of the core. Generates the 35-bit core instruction word each cycle.
- For one tile it runs: weight fetch, weight load, activation fetch, execute, and drain of output FIFO results into psum memory.
- Replaces hand-driven testbench instruction streams. The host provides base addresses and a start pulse, then waits for done.

Parameters:
row, 8, PE array rows; width of a weight/activation vector in elements
col, 8, PE array columns; number of weight vectors per tile
addr_bw, 11, SRAM address width (xmem and pmem)
prop_gap, 16, idle cycles after weight load for weight propagation (row+col)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a tile when idle
w_base  input  addr_bw  xmem address of first weight vector
x_base  input  addr_bw  xmem address of first activation vector
p_base  input  addr_bw  pmem address for first result
num_act  input  addr_bw  activation vectors per tile (1..2047)
relu_en  input  1  copied to inst[34] during drain
acc_en  input  1  copied to inst[33] during drain
ofifo_valid  input  1  core has a result vector available
inst  output  35  core instruction word
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse on tile completion

Behaviour:
- Instruction fields:
  - [34] relu; [33] accumulate.
  - [32] pmem CEN; [31] pmem WEN; [30:20] pmem addr. CEN and WEN are active-low.
  - [19] xmem CEN; [18] xmem WEN; [17:7] xmem addr. CEN and WEN are active-low.
  - [6] ofifo_rd; [5:4] held 0; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
- Idle word (IDLE_INST): 35'h1_800C_0000. Both memories are disabled; all other bits are 0.
- Reset (reset=0, async):
  - State goes to IDLE; all counters go to 0.
  - inst=IDLE_INST, busy=0, done=0.
  - Reset mid-tile abandons the tile; no done pulse is issued.
- inst, busy and done are registered outputs.
- IDLE: inst=IDLE_INST. A start pulse latches all bases, num_act, relu_en and acc_en, sets busy=1 and enters WFETCH. While busy, start is ignored.
- WFETCH (col+1 cycles):
  - Cycles 0..col-1: xmem CEN=0, WEN=1, addr=w_base+i.
  - Cycles 1..col: l0_wr=1, because SRAM read latency is 1 cycle and l0_wr trails the address by one cycle.
- WLOAD (col cycles): l0_rd=1, load=1.
- WPROP (prop_gap cycles): inst=IDLE_INST.
- XFETCH (num_act+1 cycles): same pattern as WFETCH, using x_base and num_act.
- EXEC (num_act cycles): l0_rd=1, execute=1.
- DRAIN (count d from 0 to num_act-1):
  - In a cycle with ofifo_valid=1: ofifo_rd=1, pmem CEN=0, WEN=0, addr=p_base+d, [34]=relu_en, [33]=acc_en; d increments.
  - In a cycle with ofifo_valid=0: inst=IDLE_INST and d holds.
  - The cycle after the write with d=num_act-1: state goes to IDLE, done=1 for one cycle, busy=0.
- Address arithmetic is modulo 2^addr_bw; base+i wraps past 2047 to 0.
- num_act=0 is treated as 1.
- No state issues a pmem write and an xmem access in the same cycle.
- Total cycles from start to done with ofifo_valid always high: 2·col+2·num_act+prop_gap+2+num_act+1, counted as registered latency.

Test Plan:
1. Reset: assert reset=0 mid-EXEC → inst=35'h1_800C_0000 immediately, busy=0, no done; after release, start works normally.
2. Weight phase: w_base=0, start → xmem addr 0..7 on consecutive cycles with CEN=0/WEN=1; l0_wr high on those 8 cycles, each delayed by one; then 8 cycles of l0_rd=1,load=1; then 16 idle cycles.
3. Full tile: x_base=100, p_base=5, num_act=36, ofifo_valid tied 1 → 36 execute cycles; pmem writes to 5..40 with ofifo_rd=1; done pulses once; cycle count matches the formula.
4. Drain stall: toggle ofifo_valid 1,0,0,1,... → pmem writes and ofifo_rd occur only on valid cycles; addresses stay contiguous with no skips or duplicates.
5. Wrap and flags: x_base=2046, p_base=2047, num_act=4, relu_en=1, acc_en=1 → xmem addrs 2046,2047,0,1; pmem addrs 2047,0,1,2; inst[34:33]=2'b11 only on drain write cycles.
6. Start while busy: pulse start during XFETCH with different bases → ignored; original tile completes unchanged.
